move_check: RTL and testbench
=============================

MOVE_CHECK -- requirements
Module: move_check

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to evaluate a move; sampled only in IDLE.
REQ-005 X  input  3  target column 0..7.
REQ-006 Y  input  3  target row 0..7.
REQ-007 player  input  1  mover colour: 1 = RED, 0 = BLUE.
REQ-008 B  input  64  blue disc board, bit index Y*8+X.
REQ-009 R  input  64  red disc board, same indexing.
REQ-010 busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-012 legal  output  1  move flanks at least one opponent disc.
REQ-013 occupied  output  1  target square already holds a disc.
REQ-014 dir_mask  output  8  bit d set when direction d flanks.
REQ-015 flip_count  output  6  total opponent discs flanked across all directions.

Function
REQ-016 Own board SHALL be R when player=1, else B; opponent board SHALL be the other; both are latched together with X, Y at accept.
REQ-017 Directions (dx,dy) SHALL be: 0 (+1,0), 1 (-1,0), 2 (0,+1), 3 (0,-1), 4 (+1,+1), 5 (-1,+1), 6 (+1,-1), 7 (-1,-1); scanned in order 0..7.
REQ-018 States SHALL be IDLE, SCAN, DONE.
REQ-019 IDLE: start=1 with target occupied (B|R bit set on live inputs) SHALL go to DONE, with occupied=1, legal=0, dir_mask=0, flip_count=0.
REQ-020 IDLE: start=1 with target empty SHALL go to SCAN, with dir=0, pos=target, run=0, and all result outputs cleared.
REQ-021 SCAN SHALL examine exactly one square per cycle: next = pos+(dx,dy) of current dir.
REQ-022 If next is off-board (X or Y outside 0..7, detected before 3-bit wrap), the direction SHALL fail.
REQ-023 If next is an opponent disc, SCAN SHALL set pos=next and run=run+1, staying on the same dir.
REQ-024 If next is an own disc and run>=1, the direction SHALL succeed: dir_mask[dir] set, flip_count += run.
REQ-025 If next is an own disc with run=0, or next is empty, the direction SHALL fail.
REQ-026 On direction end, the same cycle SHALL either go to DONE if dir=7, or set dir+1, pos=target, run=0.
REQ-027 Each direction SHALL consume k+1 SCAN cycles, where k = consecutive opponent discs from the target in that direction.
REQ-028 With the start cycle = 0: done SHALL assert at cycle 1 for an occupied target, else at cycle 1+Σ(k_d+1); minimum 9, maximum 1+8+Σk_d.
REQ-029 legal SHALL equal (dir_mask != 0) and SHALL be written when entering DONE.
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031 Results SHALL hold until the next accepted start.
REQ-032 start while busy SHALL be ignored; a start in the same cycle as done is ignored; a start in the first IDLE cycle after done is accepted.
REQ-033 Input changes to B/R/X/Y/player during SCAN SHALL have no effect.

Reset
REQ-034 RST SHALL force state IDLE, busy=0, done=0, legal=0, occupied=0, dir_mask=0, flip_count=0, and clear internal counters.
REQ-035 RST SHALL take priority over start.
REQ-036 RST mid-scan SHALL abort the scan with no done pulse.

Verification
REQ-037 Opening board (B bits 28,35; R bits 27,36), player=0, X=2, Y=3, start at cycle 0 -> done at cycle 10, legal=1, dir_mask=0x01, flip_count=1, occupied=0.
REQ-038 Same board, player=0, X=3, Y=3 -> done at cycle 1, occupied=1, legal=0, dir_mask=0, flip_count=0.
REQ-039 Same board, player=0, X=0, Y=0 -> done at cycle 9, legal=0, dir_mask=0.
REQ-040 B bits 1..6, R bit 7, player=1, X=0, Y=0 -> done at cycle 15, legal=1, dir_mask=0x01, flip_count=6.
REQ-041 B bits 1..7, R=0, player=1, X=0, Y=0 (run hits edge) -> done at cycle 16, legal=0, flip_count=0.
REQ-042 Scan from REQ-037 with a second start at cycle 3 and RST at cycle 5 -> no done, all outputs 0 at cycle 6; a new start at cycle 7 completes normally at cycle 17.

Source files
------------

// File: rtl/move_check.sv
// Reversi move checker: scans all eight directions from a target square and
// reports which directions flank opponent discs and how many would be flipped.
module move_check (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic [2:0]  X,
  input  logic [2:0]  Y,
  input  logic        player,
  input  logic [63:0] B,
  input  logic [63:0] R,
  output logic        busy,
  output logic        done,
  output logic        legal,
  output logic        occupied,
  output logic [7:0]  dir_mask,
  output logic [5:0]  flip_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [63:0] r_own;
  logic [63:0] r_opp;
  logic [2:0]  r_tgtX;
  logic [2:0]  r_tgtY;
  logic [2:0]  r_posX;
  logic [2:0]  r_posY;
  logic [2:0]  r_dir;
  logic [2:0]  r_run;
  logic        r_legal;
  logic        r_occupied;
  logic [7:0]  r_dirMask;
  logic [5:0]  r_flipCount;

  logic [63:0] w_liveBoard;
  logic        w_targetOcc;
  logic        w_xInc;
  logic        w_xDec;
  logic        w_yInc;
  logic        w_yDec;
  logic [3:0]  w_nextX;
  logic [3:0]  w_nextY;
  logic        w_offBoard;
  logic [5:0]  w_nextIdx;
  logic        w_isOpp;
  logic        w_isOwn;
  logic        w_dirWin;
  logic        w_lastDir;
  logic [7:0]  w_dirBit;
  logic [7:0]  w_maskNext;

  assign w_liveBoard = B | R;
  assign w_targetOcc = w_liveBoard[{Y, X}];

  always_comb begin
    w_xInc = 1'b0;
    w_xDec = 1'b0;
    w_yInc = 1'b0;
    w_yDec = 1'b0;
    case (r_dir)
      3'd0: w_xInc = 1'b1;
      3'd1: w_xDec = 1'b1;
      3'd2: w_yInc = 1'b1;
      3'd3: w_yDec = 1'b1;
      3'd4: begin w_xInc = 1'b1; w_yInc = 1'b1; end
      3'd5: begin w_xDec = 1'b1; w_yInc = 1'b1; end
      3'd6: begin w_xInc = 1'b1; w_yDec = 1'b1; end
      default: begin w_xDec = 1'b1; w_yDec = 1'b1; end
    endcase
  end

  // One spare bit catches both 7+1 and 0-1 as bit 3 set, before any 3-bit wrap.
  assign w_nextX    = {1'b0, r_posX} + {3'b000, w_xInc} - {3'b000, w_xDec};
  assign w_nextY    = {1'b0, r_posY} + {3'b000, w_yInc} - {3'b000, w_yDec};
  assign w_offBoard = w_nextX[3] | w_nextY[3];
  assign w_nextIdx  = {w_nextY[2:0], w_nextX[2:0]};
  assign w_isOpp    = !w_offBoard && r_opp[w_nextIdx];
  assign w_isOwn    = !w_offBoard && r_own[w_nextIdx];
  assign w_dirWin   = w_isOwn && (r_run != 3'd0);
  assign w_lastDir  = (r_dir == 3'd7);
  assign w_dirBit   = 8'd1 << r_dir;
  assign w_maskNext = w_dirWin ? (r_dirMask | w_dirBit) : r_dirMask;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_targetOcc ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (!w_isOpp && w_lastDir) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // A direction ends on anything other than an opponent disc; that same cycle
  // either rewinds to the target for the next direction or finalises legal.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_own       <= '0;
      r_opp       <= '0;
      r_tgtX      <= '0;
      r_tgtY      <= '0;
      r_posX      <= '0;
      r_posY      <= '0;
      r_dir       <= '0;
      r_run       <= '0;
      r_legal     <= 1'b0;
      r_occupied  <= 1'b0;
      r_dirMask   <= '0;
      r_flipCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_own       <= player ? R : B;
            r_opp       <= player ? B : R;
            r_tgtX      <= X;
            r_tgtY      <= Y;
            r_posX      <= X;
            r_posY      <= Y;
            r_dir       <= '0;
            r_run       <= '0;
            r_occupied  <= w_targetOcc;
            r_legal     <= 1'b0;
            r_dirMask   <= '0;
            r_flipCount <= '0;
          end
        end
        SCAN: begin
          if (w_isOpp) begin
            r_posX <= w_nextX[2:0];
            r_posY <= w_nextY[2:0];
            r_run  <= r_run + 3'd1;
          end else begin
            r_dirMask <= w_maskNext;
            if (w_dirWin) begin
              r_flipCount <= r_flipCount + {3'b000, r_run};
            end
            r_run  <= '0;
            r_posX <= r_tgtX;
            r_posY <= r_tgtY;
            if (w_lastDir) begin
              r_legal <= (w_maskNext != 8'd0);
            end else begin
              r_dir <= r_dir + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign legal      = r_legal;
  assign occupied   = r_occupied;
  assign dir_mask   = r_dirMask;
  assign flip_count = r_flipCount;

endmodule

// File: tb/tb_move_check.sv
// Scoreboard bench for move_check: expected results are queued when a move is
// launched and compared when the done pulse arrives.
module tb_move_check;

  typedef struct packed {
    int         lat;
    logic       legal;
    logic       occ;
    logic [7:0] mask;
    logic [5:0] cnt;
  } exp_t;

  logic        clk;
  logic        RST;
  logic        start;
  logic [2:0]  X;
  logic [2:0]  Y;
  logic        player;
  logic [63:0] B;
  logic [63:0] R;
  logic        busy;
  logic        done;
  logic        legal;
  logic        occupied;
  logic [7:0]  dir_mask;
  logic [5:0]  flip_count;

  int   nCompared;
  int   nMismatched;
  exp_t expQ[$];

  localparam logic [63:0] OPEN_B = (64'd1 << 28) | (64'd1 << 35);
  localparam logic [63:0] OPEN_R = (64'd1 << 27) | (64'd1 << 36);

  move_check dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .X          (X),
    .Y          (Y),
    .player     (player),
    .B          (B),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .legal      (legal),
    .occupied   (occupied),
    .dir_mask   (dir_mask),
    .flip_count (flip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: walks each ray with plain integers.
  function automatic exp_t model(input logic [63:0] b, input logic [63:0] r,
                                 input logic p, input logic [2:0] x, input logic [2:0] y);
    exp_t        e;
    logic [63:0] own;
    logic [63:0] opp;
    int          dx [8];
    int          dy [8];
    int          xi;
    int          yi;
    dx  = '{1, -1, 0, 0, 1, -1, 1, -1};
    dy  = '{0, 0, 1, -1, 1, 1, -1, -1};
    own = p ? r : b;
    opp = p ? b : r;
    xi  = int'(x);
    yi  = int'(y);
    e   = '0;
    e.lat = 1;
    if (b[yi*8+xi] || r[yi*8+xi]) begin
      e.occ = 1'b1;
      return e;
    end
    for (int d = 0; d < 8; d++) begin
      int  cx;
      int  cy;
      int  k;
      bit  inb;
      cx = xi + dx[d];
      cy = yi + dy[d];
      k  = 0;
      inb = (cx >= 0 && cx < 8 && cy >= 0 && cy < 8);
      while (inb && opp[cy*8+cx]) begin
        k++;
        cx += dx[d];
        cy += dy[d];
        inb = (cx >= 0 && cx < 8 && cy >= 0 && cy < 8);
      end
      e.lat += k + 1;
      if (inb && own[cy*8+cx] && k > 0) begin
        e.mask[d] = 1'b1;
        e.cnt     = e.cnt + 6'(k);
      end
    end
    e.legal = (e.mask != 8'd0);
    return e;
  endfunction

  // Entered #1 after an edge with the DUT idle; returns #1 after the first idle edge.
  task automatic applyStimulus(input logic [63:0] b, input logic [63:0] r, input logic p,
                               input logic [2:0] x, input logic [2:0] y, input bit scramble,
                               output int lat, output logic [15:0] res);
    B = b; R = r; player = p; X = x; Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 200) begin
      if (scramble && lat == 2) begin
        B = ~b; R = {$urandom, $urandom}; player = ~p; X = ~x; Y = ~y;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    res = {legal, occupied, dir_mask, flip_count};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; X = 3'd2; Y = 3'd3; player = 1'b0; B = OPEN_B; R = OPEN_R;
    repeat (3) @(posedge clk);
    #1;
    nCompared++;
    if ({busy, done, legal, occupied, dir_mask, flip_count} !== 18'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %h want 0", {busy, done, legal, occupied, dir_mask, flip_count});
    end
    RST = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    nCompared++;
    if ({busy, done} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: busy/done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_opening();
    logic [2:0]  xs [3];
    logic [2:0]  ys [3];
    int          lat;
    logic [15:0] res;
    exp_t        e;
    xs = '{3'd2, 3'd3, 3'd0};
    ys = '{3'd3, 3'd3, 3'd0};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       expQ.push_back('{lat: 10, legal: 1'b1, occ: 1'b0, mask: 8'h01, cnt: 6'd1});
        1:       expQ.push_back('{lat: 1,  legal: 1'b0, occ: 1'b1, mask: 8'h00, cnt: 6'd0});
        default: expQ.push_back('{lat: 9,  legal: 1'b0, occ: 1'b0, mask: 8'h00, cnt: 6'd0});
      endcase
      applyStimulus(OPEN_B, OPEN_R, 1'b0, xs[i], ys[i], 1'b0, lat, res);
      e = expQ.pop_front();
      nCompared++;
      if (lat !== e.lat) begin
        nMismatched++;
        $display("[TB] FAIL opening%0d_latency: got %0d want %0d", i, lat, e.lat);
      end
      nCompared++;
      if (res !== {e.legal, e.occ, e.mask, e.cnt}) begin
        nMismatched++;
        $display("[TB] FAIL opening%0d_result: got %h want %h", i, res, {e.legal, e.occ, e.mask, e.cnt});
      end
    end
  endtask

  task automatic test_long_runs();
    logic [63:0] bb;
    logic [63:0] rr;
    int          lat;
    logic [15:0] res;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        bb = 64'h0000_0000_0000_007E;
        rr = 64'h0000_0000_0000_0080;
        expQ.push_back('{lat: 15, legal: 1'b1, occ: 1'b0, mask: 8'h01, cnt: 6'd6});
      end else begin
        bb = 64'h0000_0000_0000_00FE;
        rr = 64'h0;
        expQ.push_back('{lat: 16, legal: 1'b0, occ: 1'b0, mask: 8'h00, cnt: 6'd0});
      end
      applyStimulus(bb, rr, 1'b1, 3'd0, 3'd0, 1'b0, lat, res);
      e = expQ.pop_front();
      nCompared++;
      if (lat !== e.lat) begin
        nMismatched++;
        $display("[TB] FAIL longrun%0d_latency: got %0d want %0d", i, lat, e.lat);
      end
      nCompared++;
      if (res !== {e.legal, e.occ, e.mask, e.cnt}) begin
        nMismatched++;
        $display("[TB] FAIL longrun%0d_result: got %h want %h", i, res, {e.legal, e.occ, e.mask, e.cnt});
      end
    end
  endtask

  task automatic test_frozen_inputs();
    int          lat;
    logic [15:0] res;
    exp_t        e;
    expQ.push_back('{lat: 10, legal: 1'b1, occ: 1'b0, mask: 8'h01, cnt: 6'd1});
    applyStimulus(OPEN_B, OPEN_R, 1'b0, 3'd2, 3'd3, 1'b1, lat, res);
    e = expQ.pop_front();
    nCompared++;
    if (lat !== e.lat || res !== {e.legal, e.occ, e.mask, e.cnt}) begin
      nMismatched++;
      $display("[TB] FAIL frozen_inputs: got lat %0d res %h want lat %0d res %h",
               lat, res, e.lat, {e.legal, e.occ, e.mask, e.cnt});
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    exp_t e;
    expQ.push_back('{lat: 9, legal: 1'b0, occ: 1'b0, mask: 8'h00, cnt: 6'd0});
    expQ.push_back('{lat: 1, legal: 1'b0, occ: 1'b1, mask: 8'h00, cnt: 6'd0});
    B = OPEN_B; R = OPEN_R; player = 1'b0; X = 3'd0; Y = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = expQ.pop_front();
    nCompared++;
    if (cyc !== e.lat || {legal, occupied, dir_mask, flip_count} !== {e.legal, e.occ, e.mask, e.cnt}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got cyc %0d res %h want cyc %0d res %h",
               cyc, {legal, occupied, dir_mask, flip_count}, e.lat, {e.legal, e.occ, e.mask, e.cnt});
    end
    X = 3'd3; Y = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    nCompared++;
    if ({busy, done} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL b2b_start_on_done_ignored: busy/done got %b want 00", {busy, done});
    end
    @(posedge clk); #1;
    start = 1'b0;
    e = expQ.pop_front();
    nCompared++;
    if ({done, legal, occupied, dir_mask, flip_count} !== {1'b1, e.legal, e.occ, e.mask, e.cnt}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got %h want %h",
               {done, legal, occupied, dir_mask, flip_count}, {1'b1, e.legal, e.occ, e.mask, e.cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midscan();
    bit          sawDone;
    int          lat;
    logic [15:0] res;
    exp_t        e;
    sawDone = 1'b0;
    B = OPEN_B; R = OPEN_R; player = 1'b0; X = 3'd2; Y = 3'd3; start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) start = 1'b1;
      if (cyc == 4) start = 1'b0;
      if (cyc == 5) RST = 1'b1;
      if (cyc == 6) RST = 1'b0;
    end
    nCompared++;
    if (sawDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midscan_no_done: got done seen %0d want 0", sawDone);
    end
    nCompared++;
    if ({busy, done, legal, occupied, dir_mask, flip_count} !== 18'd0) begin
      nMismatched++;
      $display("[TB] FAIL midscan_cleared: got %h want 0", {busy, done, legal, occupied, dir_mask, flip_count});
    end
    @(posedge clk); #1;
    expQ.push_back('{lat: 10, legal: 1'b1, occ: 1'b0, mask: 8'h01, cnt: 6'd1});
    applyStimulus(OPEN_B, OPEN_R, 1'b0, 3'd2, 3'd3, 1'b0, lat, res);
    e = expQ.pop_front();
    nCompared++;
    if (lat !== e.lat || res !== {e.legal, e.occ, e.mask, e.cnt}) begin
      nMismatched++;
      $display("[TB] FAIL midscan_restart: got lat %0d res %h want lat %0d res %h",
               lat, res, e.lat, {e.legal, e.occ, e.mask, e.cnt});
    end
  endtask

  task automatic test_random();
    logic [63:0] bb;
    logic [63:0] rr;
    logic [63:0] fill;
    logic        p;
    logic [2:0]  x;
    logic [2:0]  y;
    int          lat;
    logic [15:0] res;
    exp_t        e;
    for (int i = 0; i < 24; i++) begin
      fill = {$urandom, $urandom} | {$urandom, $urandom};
      bb   = {$urandom, $urandom} & fill;
      rr   = ~bb & fill;
      p    = 1'($urandom_range(0, 1));
      x    = 3'($urandom_range(0, 7));
      y    = 3'($urandom_range(0, 7));
      if (i % 2 == 0) begin
        bb[{y, x}] = 1'b0;
        rr[{y, x}] = 1'b0;
      end
      expQ.push_back(model(bb, rr, p, x, y));
      applyStimulus(bb, rr, p, x, y, 1'b0, lat, res);
      e = expQ.pop_front();
      nCompared++;
      if (lat !== e.lat || res !== {e.legal, e.occ, e.mask, e.cnt}) begin
        nMismatched++;
        $display("[TB] FAIL random%0d: got lat %0d res %h want lat %0d res %h",
                 i, lat, res, e.lat, {e.legal, e.occ, e.mask, e.cnt});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_opening();
    test_long_runs();
    test_frozen_inputs();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
